// File: rtl/decoder3_8_pulse_pkg.sv
// ============================================================================
// decoder3_8_pulse_pkg : state encoding and widths for decoder3_8_pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

package decoder3_8_pulse_pkg;

   localparam int ONEHOT8 = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } dec_state_t;

endpackage

`default_nettype wire

// File: rtl/decoder3_8_pulse_hold_counter.sv
// ============================================================================
// decoder3_8_pulse_hold_counter : loadable down-counter with zero flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module decoder3_8_pulse_hold_counter #(
   parameter int HOLD_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   input  logic              en,
   output logic [HOLD_W-1:0] count,
   output logic              zero
);

   logic [HOLD_W-1:0] count_q;
   logic [HOLD_W-1:0] count_d;

   // Load wins over decrement; the counter parks at zero rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - HOLD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/decoder3_8_pulse.sv
// ============================================================================
// decoder3_8_pulse : registered 3-to-8 decoder with timed one-hot pulse and scan
// Revision: 1.0
// ============================================================================
`default_nettype none

module decoder3_8_pulse
   import decoder3_8_pulse_pkg::*;
#(
   parameter int HOLD_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2:0]         in_code,
   input  logic [HOLD_W-1:0]  hold,
   input  logic               scan_en,
   output logic [ONEHOT8-1:0] out,
   output logic               busy,
   output logic               done
);

   localparam logic [ONEHOT8-1:0] ONE_LSB = {{(ONEHOT8-1){1'b0}}, 1'b1};

   dec_state_t         state_q, state_d;
   logic [ONEHOT8-1:0] out_q, out_d;
   logic               done_q, done_d;
   logic [2:0]         scan_ptr_q, scan_ptr_d;

   logic               cnt_load;
   logic               cnt_en;
   logic [HOLD_W-1:0]  cnt_load_val;
   logic [HOLD_W-1:0]  cnt_count;
   logic               cnt_zero;

   // hold=0 behaves as a one-cycle pulse, so the reload value saturates at 0.
   assign cnt_load_val = (hold == '0) ? '0 : (hold - HOLD_W'(1));

   decoder3_8_pulse_hold_counter #(
      .HOLD_W (HOLD_W)
   ) u_hold_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .en       (cnt_en),
      .count    (cnt_count),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d    = state_q;
      out_d      = out_q;
      done_d     = 1'b0;
      scan_ptr_d = scan_ptr_q;
      cnt_load   = 1'b0;
      cnt_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               out_d    = ONE_LSB << in_code;
               cnt_load = 1'b1;
               state_d  = HOLD;
            end else if (scan_en) begin
               out_d    = ONE_LSB << scan_ptr_q;
               cnt_load = 1'b1;
               state_d  = SCAN;
            end
         end
         HOLD, SCAN: begin
            if (!cnt_zero) begin
               cnt_en = 1'b1;
            end else begin
               out_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
               if (state_q == SCAN) begin
                  scan_ptr_d = scan_ptr_q + 3'd1;
               end
            end
         end
         default: begin
            out_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         out_q      <= '0;
         done_q     <= 1'b0;
         scan_ptr_q <= 3'd0;
      end else begin
         state_q    <= state_d;
         out_q      <= out_d;
         done_q     <= done_d;
         scan_ptr_q <= scan_ptr_d;
      end
   end

   assign in_ready = (state_q == IDLE);
   assign busy     = (state_q != IDLE);
   assign out      = out_q;
   assign done     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder3_8_pulse.sv
// ============================================================================
// tb_decoder3_8_pulse : directed self-checking bench for decoder3_8_pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_decoder3_8_pulse;

   localparam int HOLD_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_code;
   logic [HOLD_W-1:0] hold;
   logic              scan_en;
   logic [7:0]        out;
   logic              busy;
   logic              done;

   int n_cmp = 0;
   int n_bad = 0;

   decoder3_8_pulse #(.HOLD_W(HOLD_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .hold     (hold),
      .scan_en  (scan_en),
      .out      (out),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; hold = '0; scan_en = 1'b0;
      tick(); tick();
      rst = 1'b0;
      n_cmp++;
      if (out !== 8'h00) begin n_bad++; $display("FAIL reset_out got=%h exp=00", out); end
      n_cmp++;
      if ({busy, done, in_ready} !== 3'b001) begin
         n_bad++; $display("FAIL reset_flags busy/done/rdy got=%b exp=001", {busy, done, in_ready});
      end
   endtask

   task automatic test_single_pulse();
      logic [7:0] exp_out [5] = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
      logic [2:0] exp_fl  [5] = '{3'b100, 3'b100, 3'b100, 3'b011, 3'b001};
      in_valid = 1'b1; in_code = 3'd5; hold = 4'd3;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (out !== exp_out[i]) begin n_bad++; $display("FAIL single_out[%0d] got=%h exp=%h", i, out, exp_out[i]); end
         n_cmp++;
         if ({busy, done, in_ready} !== exp_fl[i]) begin
            n_bad++; $display("FAIL single_flags[%0d] got=%b exp=%b", i, {busy, done, in_ready}, exp_fl[i]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_out [4] = '{8'h80, 8'h80, 8'h00, 8'h00};
      logic       exp_dn  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      in_valid = 1'b1; in_code = 3'd0; hold = 4'd0;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out !== 8'h01) begin n_bad++; $display("FAIL b2b_first got=%h exp=01", out); end
      tick();
      n_cmp++;
      if ({out, done, in_ready} !== {8'h00, 2'b11}) begin
         n_bad++; $display("FAIL b2b_gap out/done/rdy got=%h/%b/%b exp=00/1/1", out, done, in_ready);
      end
      in_valid = 1'b1; in_code = 3'd7; hold = 4'd2;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if ({out, done} !== {exp_out[i], exp_dn[i]}) begin
            n_bad++; $display("FAIL b2b_second[%0d] out/done got=%h/%b exp=%h/%b", i, out, done, exp_out[i], exp_dn[i]);
         end
         tick();
      end
   endtask

   task automatic test_scan_wrap();
      logic [7:0] exp_out;
      logic       exp_dn;
      scan_en = 1'b1; hold = 4'd1;
      for (int k = 1; k <= 18; k++) begin
         tick();
         exp_out = (k % 2 == 1) ? (8'h01 << (((k - 1) / 2) % 8)) : 8'h00;
         exp_dn  = (k % 2 == 0);
         n_cmp++;
         if ({out, done} !== {exp_out, exp_dn}) begin
            n_bad++; $display("FAIL scan[%0d] out/done got=%h/%b exp=%h/%b", k, out, done, exp_out, exp_dn);
         end
         if (k == 17) scan_en = 1'b0;
      end
      tick();
      n_cmp++;
      if ({out, done, busy} !== {8'h00, 2'b00}) begin
         n_bad++; $display("FAIL scan_stopped out/done/busy got=%h/%b/%b exp=00/0/0", out, done, busy);
      end
   endtask

   task automatic test_priority_and_stop();
      logic [7:0] exp_out [6] = '{8'h02, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00};
      logic       exp_dn  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      // Scan pointer is 1 here after the wrap test.
      scan_en = 1'b1; in_valid = 1'b1; in_code = 3'd3; hold = 4'd1;
      tick();
      in_valid = 1'b0; hold = 4'd3;
      n_cmp++;
      if ({out, busy, in_ready} !== {8'h08, 2'b10}) begin
         n_bad++; $display("FAIL prio_out out/busy/rdy got=%h/%b/%b exp=08/1/0", out, busy, in_ready);
      end
      tick();
      n_cmp++;
      if ({out, done} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL prio_end out/done got=%h/%b exp=00/1", out, done); end
      tick();
      scan_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({out, done} !== {exp_out[i], exp_dn[i]}) begin
            n_bad++; $display("FAIL stop[%0d] out/done got=%h/%b exp=%h/%b", i, out, done, exp_out[i], exp_dn[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1; in_code = 3'd4; hold = 4'd6;
      tick();
      in_valid = 1'b0;
      n_cmp++;
      if (out !== 8'h10) begin n_bad++; $display("FAIL rmid_c1 got=%h exp=10", out); end
      tick();
      n_cmp++;
      if (out !== 8'h10) begin n_bad++; $display("FAIL rmid_c2 got=%h exp=10", out); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++;
      if ({out, busy, done, in_ready} !== {8'h00, 3'b001}) begin
         n_bad++; $display("FAIL rmid_cleared out/busy/done/rdy got=%h/%b/%b/%b exp=00/0/0/1", out, busy, done, in_ready);
      end
      tick();
      n_cmp++;
      if ({out, done} !== {8'h00, 1'b0}) begin n_bad++; $display("FAIL rmid_nodone out/done got=%h/%b exp=00/0", out, done); end
      // Scan pointer was 2 before reset; the first scan step must be code 0.
      scan_en = 1'b1; hold = 4'd1;
      tick();
      scan_en = 1'b0;
      n_cmp++;
      if (out !== 8'h01) begin n_bad++; $display("FAIL rmid_ptr got=%h exp=01", out); end
   endtask

   initial begin
      test_reset();
      test_single_pulse();
      test_back_to_back();
      test_scan_wrap();
      test_priority_and_stop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
